seg_serial_shifter: RTL

Downstream stage of the 8-digit hex-to-segment decoder. Takes the decoder's 64-bit segment pattern, captures it on a start request, and shifts it out serially to the board's external shift-register chain that drives the 7-segment displays. A latch pulse then transfers the shifted data to the display outputs. The block generates its own divided shift clock and reports busy/done so a controller can pace refreshes.

---
 rtl/seg_serial_shifter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_serial_shifter.sv
// seg_serial_shifter: shifts a captured segment frame into the external
// display shift-register chain, then strobes the parallel latch.
// Optional feature macro: SEG_AUTO_REFRESH_EN (periodic self-started frames).
module seg_serial_shifter #(
    parameter int WIDTH       = 64,
    parameter int DIV         = 2,
    parameter int REFRESH_GAP = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seg_txt,
    output logic             sclk,
    output logic             sdata,
    output logic             sclr_n,
    output logic             latch,
    output logic             busy,
    output logic             done
);

    localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    if (DIV < 1 || DIV > 255) begin : g_bad_div
        $error("seg_serial_shifter: DIV must be within 1..255");
    end

    if (REFRESH_GAP < 1) begin : g_bad_gap
        $error("seg_serial_shifter: REFRESH_GAP must be at least 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [7:0]       div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_sh;

    logic auto_go;
    logic frame_go;
    logic div_end;
    logic low_end;
    logic high_end;
    logic last_bit;
    logic latch_end;

    // Shadow shifted by one: its MSB is the next bit to present on sdata.
    assign shadow_sh = shadow << 1;

`ifdef SEG_AUTO_REFRESH_EN
    localparam int            IW        = $clog2(REFRESH_GAP + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(REFRESH_GAP - 1);

    logic [IW-1:0] idle_cnt;

    // Count consecutive idle cycles; any frame start restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != S_IDLE || frame_go) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign auto_go = (state == S_IDLE) && (idle_cnt == IDLE_LAST);
`else
    assign auto_go = 1'b0;
`endif

    // Decode the timing events shared by the datapath registers.
    always_comb begin
        frame_go  = (state == S_IDLE) && (start || auto_go);
        div_end   = (div_cnt == DIV_LAST);
        low_end   = (state == S_SHIFT) && div_end && !sclk;
        high_end  = (state == S_SHIFT) && div_end && sclk;
        last_bit  = (bit_cnt == BIT_LAST);
        latch_end = (state == S_LATCH) && div_end;
    end

    // Frame sequencing: idle -> shift all bits -> hold latch -> idle.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (frame_go) begin
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (high_end && last_bit) begin
                    state_nx = S_LATCH;
                end
            end
            S_LATCH: begin
                if (latch_end) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Half-period divider; parked at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || div_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Bit counter advances on every falling edge of sclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (frame_go) begin
            bit_cnt <= '0;
        end else if (high_end) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Capture the frame and present bits MSB first, changing on sclk fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            sdata  <= 1'b0;
        end else if (frame_go) begin
            shadow <= seg_txt;
            sdata  <= seg_txt[WIDTH-1];
        end else if (high_end) begin
            shadow <= shadow_sh;
            sdata  <= shadow_sh[WIDTH-1];
        end
    end

    // Shift clock: rises after the low half, falls after the high half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk <= 1'b0;
        end else if (low_end) begin
            sclk <= 1'b1;
        end else if (high_end) begin
            sclk <= 1'b0;
        end
    end

    // Latch strobe spans DIV cycles after the final shift clock fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch <= 1'b0;
        end else if (high_end && last_bit) begin
            latch <= 1'b1;
        end else if (latch_end) begin
            latch <= 1'b0;
        end
    end

    // Busy covers the whole frame; done pulses as the frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= latch_end;
            if (frame_go) begin
                busy <= 1'b1;
            end else if (latch_end) begin
                busy <= 1'b0;
            end
        end
    end

    // Release the external chain clear on the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclr_n <= 1'b0;
        end else begin
            sclr_n <= 1'b1;
        end
    end

endmodule
